// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle control unit: opcode and funct
// encodings, ALU control codes, alu_op classes and the 4-bit state encoding.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // 2'b11 is never produced by the FSM
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_e;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps the FSM's alu_op class and the instruction funct
// field to the 3-bit ALU control code; flags funct values it cannot decode.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_illegal_o
);

    // Unknown funct falls back to ADD so the datapath sees a benign operation
    always_comb begin
        alu_ctrl_o      = ALU_ADD;
        funct_illegal_o = 1'b0;
        case (alu_op_i)
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the datapath mux selects, write enables and ALU control.
// Optional feature: define MULTICYCLE_CTRL_BNE_EN to support bne (op 000101).
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_e  state_q, state_d;
    state_e  dec_state;
    alu_op_e alu_op;
    logic    ir_write_s, mem_write_s, reg_write_s, pc_write, branch;
    logic    op_illegal, funct_illegal, branch_taken;

    // While reset is high every output is decoded as if in FETCH
    assign dec_state = reset ? S_FETCH : state_q;
    assign state_o   = dec_state;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    alu_decoder u_alu_dec (
        .alu_op_i        (alu_op),
        .funct_i         (funct),
        .alu_ctrl_o      (alu_ctrl),
        .funct_illegal_o (funct_illegal)
    );

    // Next-state sequencing; unsupported op in DECODE returns to FETCH
    always_comb begin
        state_d    = S_FETCH;
        op_illegal = 1'b0;
        case (dec_state)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      op_illegal = 1'b1;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = funct_illegal ? S_FETCH : S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode of the current state
    always_comb begin
        alu_op      = ALUOP_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        iord        = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        case (dec_state)
            S_FETCH:   begin ir_write_s = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; end
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB:   begin mem_to_reg = 1'b1; reg_write_s = 1'b1; end
            S_MEMWR:   begin iord = 1'b1; mem_write_s = 1'b1; end
            S_RTYPEEX: begin alu_src_a = 1'b1; alu_op = ALUOP_FUNCT; end
            S_RTYPEWB: begin reg_dst = 1'b1; reg_write_s = 1'b1; end
            S_BEQEX, S_BNEEX: begin
                alu_src_a = 1'b1; alu_op = ALUOP_SUB; pc_src = 2'b01; branch = 1'b1;
            end
            S_ADDIEX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_ADDIWB:  reg_write_s = 1'b1;
            S_JEX:     begin pc_src = 2'b10; pc_write = 1'b1; end
            default:   ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_BNE_EN
    assign branch_taken = (dec_state == S_BNEEX) ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    // Reset masks every side effect so an aborted instruction writes nothing
    assign ir_write   = ir_write_s  & ~reset;
    assign mem_write  = mem_write_s & ~reset;
    assign reg_write  = reg_write_s & ~reset;
    assign pc_en      = (pc_write | (branch & branch_taken)) & ~reset;
    assign illegal_op = (op_illegal | funct_illegal) & ~reset;

endmodule
